hm2_idrom_checker: RTL
======================

# hm2_idrom_checker

Bus-master self-check that reads back the HostMot2 config cookie and IDROM header over the internal register bus, then compares each field against the board-type constants compiled into the build. It sits beside the HostMot2 register file, on the read side of the IDROM that the board package populates. It reports per-field pass/fail so bring-up firmware and the status LED logic can detect a mismatched bitfile or adaptor configuration without software.

## Interface
- `BoardNameLow`, 32'h4153454D, expected IDROM board-name low word.
- `BoardNameHigh`, 32'h35324935, expected board-name high word.
- `FPGASize`, 9, expected FPGASize word.
- `FPGAPins`, 144, expected FPGAPins word.
- `IOPorts`, 3, expected IOPorts word.
- `IOWidth`, 72, expected IOWidth word.
- `PortWidth`, 24, expected PortWidth word.
- `ClockLow`, 50000000, expected ClockLow word.
- `ClockHigh`, 200000000, expected ClockHigh word.
- `AddrWidth`, 16, byte-address width.
- `BusWidth`, 32, data width.
- `AutoStart`, 1, when 1, begin a check automatically after reset release.
- `TimeoutCycles`, 255, ack watchdog limit; used only with the watchdog compiled in.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a check.
- `rd_req` out 1: read request.
- `rd_addr` out AddrWidth: byte address, word aligned.
- `rd_ack` in 1: read acknowledge; `rd_data` is valid in the same cycle.
- `rd_data` in BusWidth: read data.
- `busy` out 1: a check is in progress.
- `done` out 1: level; high from check completion until the next start.
- `pass` out 1: valid while `done`; 1 iff `fail_mask == 0` and `timeout == 0`.
- `fail_mask` out 11: per-read mismatch flags (see Operation).
- `timeout` out 1: the watchdog fired.

## Operation
- Read sequence, index 0..10:
  - idx0 reads @0x0100; expects 32'h55AACAFE (cookie); mismatch sets bit0.
  - idx1 reads @0x010C; the value is the IDROM pointer P. If P is 0 or P[1:0] != 0, set bit1 and go to DONE, skipping idx2..10.
  - idx2..10 read @P+0x0C+4*(idx-2), in order: BoardNameLow, BoardNameHigh, FPGASize, FPGAPins, IOPorts, IOWidth, PortWidth, ClockLow, ClockHigh. Mismatch on idx k sets bit k.
- Address arithmetic is modulo 2^AddrWidth; overflow wraps silently.
- Comparisons are full BusWidth; parameters are zero-extended.
- FSM states:
  - IDLE: wait for `start`, or the AutoStart trigger on the first cycle after reset release. On leaving, clear `fail_mask`, `timeout`, `done` and `pass`.
  - ISSUE: `rd_req` high with `rd_addr` stable until `rd_ack` is sampled.
  - NEXT: one idle cycle with `rd_req` low. Latch the compare result and compute the next address.
  - DONE: `done` high. `start` returns to ISSUE idx0.
- `start` is ignored in ISSUE and NEXT.
- `rd_ack` is ignored when `rd_req` is low.
- `busy` is high in ISSUE and NEXT.

## Timing
- Reset values: `rd_req`, `rd_addr`, `busy`, `done`, `pass`, `fail_mask` and `timeout` are all 0. State is IDLE.
- `rd_req` rises the cycle after `start` is sampled.
- Each read takes the ack latency plus 2 cycles.
- With `rd_ack` one cycle after `rd_req` rises: start at cycle 0 gives idx0 ack at cycle 2, idx10 ack at cycle 32, and `done`/`pass` registered high at cycle 33.
- `rd_req` drops the cycle after the ack. At least one low cycle separates consecutive requests.
- Reset asserted mid-read drops `rd_req` immediately. A late ack after reset release is ignored (state is IDLE).
- `done`, `pass` and `fail_mask` update together in the cycle DONE is entered.

## Configuration
- `IDROM_CHK_TIMEOUT_EN` defined:
  - An 8+ bit counter runs during ISSUE.
  - If it reaches TimeoutCycles without an ack: drop `rd_req`, set `timeout`, enter DONE with `pass=0`.
  - Bits for unread indices stay 0.
- Not defined: ISSUE waits indefinitely, and `timeout` is tied to 0.

## Test plan
- Responder returns all expected values with 1-cycle ack, P=0x0400 -> reads hit 0x0100, 0x010C, 0x040C..0x042C in order; `done`/`pass`=1 at cycle 33; `fail_mask`=0.
- Responder returns IOPorts=2 -> `fail_mask`=11'h040, `pass`=0, all 11 reads still issued.
- Cookie wrong and P=0x0402 -> `fail_mask`=11'h003; only 2 reads issued; `done` set.
- Random 0-5 cycle ack latency, plus stray `rd_ack` pulses while `rd_req` is low and `start` pulses mid-check -> identical result to scenario 1; no extra reads.
- With `IDROM_CHK_TIMEOUT_EN`, TimeoutCycles=10, no ack on idx3 -> `rd_req` drops after 10 cycles, `timeout`=1, `pass`=0, `fail_mask` bits 3..10 = 0.
- `reset` pulsed during ISSUE idx5, AutoStart=1 -> outputs clear asynchronously; a fresh check restarts at 0x0100 and passes.

Source files
------------

// File: rtl/hm2_idrom_checker_if.sv
// hm2_idrom_checker_if: start/result handshake plus the read-only register bus of the IDROM checker.
// Latency: none, wires only.
// Backpressure: the bus side holds rd_req/rd_addr until rd_ack; the master modport is the checker.
interface hm2_idrom_checker_if #(
  parameter int AddrWidth = 16,
  parameter int BusWidth  = 32
) ();
  logic                 start;
  logic                 rd_req;
  logic [AddrWidth-1:0] rd_addr;
  logic                 rd_ack;
  logic [BusWidth-1:0]  rd_data;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [10:0]          fail_mask;
  logic                 timeout;

  modport master (
    input  start, rd_ack, rd_data,
    output rd_req, rd_addr, busy, done, pass, fail_mask, timeout
  );

  modport slave (
    output start, rd_ack, rd_data,
    input  rd_req, rd_addr, busy, done, pass, fail_mask, timeout
  );
endinterface

// File: rtl/hm2_idrom_checker.sv
// hm2_idrom_checker: reads the HostMot2 cookie and IDROM header, compares each word to the build constants.
// Latency: ack latency + 2 cycles per read; done/pass/fail_mask registered the cycle after the final ack.
// Backpressure: rd_req/rd_addr held until rd_ack; optional ack watchdog when IDROM_CHK_TIMEOUT_EN is defined.
module hm2_idrom_checker #(
  parameter logic [31:0] BoardNameLow  = 32'h4153454D,
  parameter logic [31:0] BoardNameHigh = 32'h35324935,
  parameter logic [31:0] FPGASize      = 32'd9,
  parameter logic [31:0] FPGAPins      = 32'd144,
  parameter logic [31:0] IOPorts       = 32'd3,
  parameter logic [31:0] IOWidth       = 32'd72,
  parameter logic [31:0] PortWidth     = 32'd24,
  parameter logic [31:0] ClockLow      = 32'd50000000,
  parameter logic [31:0] ClockHigh     = 32'd200000000,
  parameter int          AddrWidth     = 16,
  parameter int          BusWidth      = 32,
  parameter bit          AutoStart     = 1'b1,
  parameter int          TimeoutCycles = 255
) (
  input logic                 clk,
  input logic                 reset,
  hm2_idrom_checker_if.master bus
);

  localparam logic [31:0]          Cookie       = 32'h55AACAFE;
  localparam logic [AddrWidth-1:0] CookieAddr   = AddrWidth'(32'h0100);
  localparam logic [AddrWidth-1:0] IdromPtrAddr = AddrWidth'(32'h010C);
  localparam logic [AddrWidth-1:0] HdrOffset    = AddrWidth'(32'h000C);
  localparam logic [AddrWidth-1:0] WordStep     = AddrWidth'(32'h0004);
  localparam logic [3:0]           PtrIdx       = 4'd1;
  localparam logic [3:0]           LastIdx      = 4'd10;

`ifdef IDROM_CHK_TIMEOUT_EN
  localparam int WdWidth = (TimeoutCycles > 255) ? $clog2(TimeoutCycles + 1) : 8;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_NEXT, ST_DONE} state_t;

  state_t               r_state;
  logic [3:0]           r_idx;
  logic [AddrWidth-1:0] r_ptr;
  logic [10:0]          r_acc;
  logic                 r_rd_req;
  logic [AddrWidth-1:0] r_rd_addr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [10:0]          r_fail_mask;
  logic                 r_auto_pend;
`ifdef IDROM_CHK_TIMEOUT_EN
  logic [WdWidth-1:0]   r_wd_cnt;
  logic                 r_timeout;
`endif

  logic [BusWidth-1:0]  w_expected;
  logic                 w_ptr_bad;
  logic                 w_mismatch;
  logic [10:0]          w_acc_next;

  // Expected word for the read currently in flight (idx1 is the pointer, checked separately).
  always_comb begin
    w_expected = '0;
    case (r_idx)
      4'd0:    w_expected = BusWidth'(Cookie);
      4'd2:    w_expected = BusWidth'(BoardNameLow);
      4'd3:    w_expected = BusWidth'(BoardNameHigh);
      4'd4:    w_expected = BusWidth'(FPGASize);
      4'd5:    w_expected = BusWidth'(FPGAPins);
      4'd6:    w_expected = BusWidth'(IOPorts);
      4'd7:    w_expected = BusWidth'(IOWidth);
      4'd8:    w_expected = BusWidth'(PortWidth);
      4'd9:    w_expected = BusWidth'(ClockLow);
      4'd10:   w_expected = BusWidth'(ClockHigh);
      default: w_expected = '0;
    endcase
  end

  // A null or misaligned IDROM pointer is the idx1 failure; every other index is a full-width compare.
  assign w_ptr_bad  = (bus.rd_data == '0) || (bus.rd_data[1:0] != 2'b00);
  assign w_mismatch = (r_idx == PtrIdx) ? w_ptr_bad : (bus.rd_data != w_expected);
  assign w_acc_next = r_acc | ({10'd0, w_mismatch} << r_idx);

  // Read sequencer: the mismatch bit is folded in on the ack cycle so the last read can
  // enter DONE directly, keeping the idle NEXT gap only between consecutive requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_ptr       <= '0;
      r_acc       <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= '0;
      r_auto_pend <= AutoStart;
`ifdef IDROM_CHK_TIMEOUT_EN
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_auto_pend <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start || r_auto_pend) begin
            r_state     <= ST_ISSUE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_rd_req    <= 1'b1;
            r_rd_addr   <= CookieAddr;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
`ifdef IDROM_CHK_TIMEOUT_EN
            r_wd_cnt    <= '0;
            r_timeout   <= 1'b0;
`endif
          end
        end
        ST_ISSUE: begin
          if (bus.rd_ack) begin
            r_rd_req <= 1'b0;
            r_acc    <= w_acc_next;
            if (r_idx == PtrIdx) begin
              r_ptr <= AddrWidth'(bus.rd_data);
            end
            if ((r_idx == LastIdx) || ((r_idx == PtrIdx) && w_ptr_bad)) begin
              r_state     <= ST_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_pass      <= (w_acc_next == '0);
              r_fail_mask <= w_acc_next;
            end else begin
              r_state <= ST_NEXT;
            end
          end
`ifdef IDROM_CHK_TIMEOUT_EN
          else if (r_wd_cnt == WdWidth'(TimeoutCycles - 1)) begin
            r_rd_req    <= 1'b0;
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail_mask <= r_acc;
            r_timeout   <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        ST_NEXT: begin
          r_state  <= ST_ISSUE;
          r_rd_req <= 1'b1;
          r_idx    <= r_idx + 4'd1;
`ifdef IDROM_CHK_TIMEOUT_EN
          r_wd_cnt <= '0;
`endif
          if (r_idx == 4'd0) begin
            r_rd_addr <= IdromPtrAddr;
          end else if (r_idx == PtrIdx) begin
            r_rd_addr <= r_ptr + HdrOffset;
          end else begin
            r_rd_addr <= r_rd_addr + WordStep;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_req    = r_rd_req;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.fail_mask = r_fail_mask;
`ifdef IDROM_CHK_TIMEOUT_EN
  assign bus.timeout   = r_timeout;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule
